hand_display_scan: RTL and testbench

Registered seven-segment driver for the blackjack display. It converts NUM_HANDS binary hand totals to decimal using one shared, time-multiplexed shift-add-3 converter. It also drives a 4-character status message from the game state, flashing that message in result states. It sits between the game FSM / hand accumulators and the board HEX pins.

---
 rtl/hand_display_scan.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_hand_display_scan.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hand_display_scan.sv
// Seven-segment driver for the blackjack board: one shared shift-add-3 converter scans the hand
// totals in turn, and a status message follows the game state. Optional flash: HAND_DISPLAY_BLINK_EN.
module hand_display_scan #(
    parameter int HAND_W       = 5,
    parameter int NUM_HANDS    = 2,
    parameter int HAND_DIGITS  = 2,
    parameter int BLINK_CYCLES = 25_000_000,
    parameter int STATE_W      = 3,
    parameter logic [STATE_W-1:0] S_RESET       = 3'd0,
    parameter logic [STATE_W-1:0] S_RESULT_WIN  = 3'd5,
    parameter logic [STATE_W-1:0] S_RESULT_LOSE = 3'd6,
    parameter logic [STATE_W-1:0] S_RESULT_TIE  = 3'd7
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_HANDS*HAND_W-1:0]       i_hand_vals,
    input  logic [STATE_W-1:0]                i_game_state,
    output logic [NUM_HANDS*HAND_DIGITS*7-1:0] o_hex_hands,
    output logic [27:0]                       o_hex_msg,
    output logic [NUM_HANDS-1:0]              o_hand_upd
);

    localparam int IDX_W = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;
    localparam int BIT_W = (HAND_W > 1) ? $clog2(HAND_W) : 1;
    localparam int BCD_W = 4 * HAND_DIGITS;
    localparam int SR_W  = BCD_W + HAND_W;
    localparam int HGL_W = HAND_DIGITS * 7;

    function automatic int unsigned pow10(input int n);
        int unsigned p;
        p = 32'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p;
    endfunction

    localparam int unsigned OVF_LIMIT = pow10(HAND_DIGITS);

    if ((4 * HAND_DIGITS < HAND_W) || (BLINK_CYCLES < 1)) begin : g_param_check
        $error("hand_display_scan: HAND_DIGITS too small for HAND_W or BLINK_CYCLES < 1");
    end

    // Character codes of the shared seven-segment decoder (0..9 are the decimal digits).
    localparam logic [4:0] C_A     = 5'd10;
    localparam logic [4:0] C_B     = 5'd11;
    localparam logic [4:0] C_E     = 5'd12;
    localparam logic [4:0] C_I     = 5'd13;
    localparam logic [4:0] C_J     = 5'd14;
    localparam logic [4:0] C_K     = 5'd15;
    localparam logic [4:0] C_L     = 5'd16;
    localparam logic [4:0] C_N     = 5'd17;
    localparam logic [4:0] C_O     = 5'd18;
    localparam logic [4:0] C_P     = 5'd19;
    localparam logic [4:0] C_R     = 5'd20;
    localparam logic [4:0] C_S     = 5'd21;
    localparam logic [4:0] C_T     = 5'd22;
    localparam logic [4:0] C_W     = 5'd23;
    localparam logic [4:0] C_Y     = 5'd24;
    localparam logic [4:0] C_DASH  = 5'd25;
    localparam logic [4:0] C_BLANK = 5'd31;

    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'h40;
            5'd1:    seg = 7'h79;
            5'd2:    seg = 7'h24;
            5'd3:    seg = 7'h30;
            5'd4:    seg = 7'h19;
            5'd5:    seg = 7'h12;
            5'd6:    seg = 7'h02;
            5'd7:    seg = 7'h78;
            5'd8:    seg = 7'h00;
            5'd9:    seg = 7'h10;
            C_A:     seg = 7'h08;
            C_B:     seg = 7'h03;
            C_E:     seg = 7'h06;
            C_I:     seg = 7'h4F;
            C_J:     seg = 7'h61;
            C_K:     seg = 7'h09;
            C_L:     seg = 7'h47;
            C_N:     seg = 7'h2B;
            C_O:     seg = 7'h40;
            C_P:     seg = 7'h0C;
            C_R:     seg = 7'h2F;
            C_S:     seg = 7'h12;
            C_T:     seg = 7'h07;
            C_W:     seg = 7'h41;
            C_Y:     seg = 7'h11;
            C_DASH:  seg = 7'h3F;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r = v;
        for (int d = 0; d < HAND_DIGITS; d++) begin
            nib = v[d*4 +: 4];
            if (nib >= 4'd5) begin
                r[d*4 +: 4] = nib + 4'd3;
            end else begin
                r[d*4 +: 4] = nib;
            end
        end
        return r;
    endfunction

    // Leading zeros above the ones digit are blanked; overflow turns the whole hand into dashes.
    function automatic logic [HGL_W-1:0] hand_glyphs(input logic [BCD_W-1:0] bcd, input logic ovf);
        logic [HGL_W-1:0] segs;
        logic             lead;
        logic [3:0]       nib;
        segs = '1;
        lead = 1'b1;
        for (int d = HAND_DIGITS - 1; d >= 0; d--) begin
            nib = bcd[d*4 +: 4];
            if (ovf) begin
                segs[d*7 +: 7] = seg_decode(C_DASH);
            end else if (lead && (nib == 4'd0) && (d != 0)) begin
                segs[d*7 +: 7] = seg_decode(C_BLANK);
            end else begin
                segs[d*7 +: 7] = seg_decode({1'b0, nib});
                lead = 1'b0;
            end
        end
        return segs;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } conv_state_t;

    conv_state_t       r_conv_state;
    conv_state_t       w_conv_next;
    logic [IDX_W-1:0]  r_idx;
    logic [BIT_W-1:0]  r_bit;
    logic [BCD_W-1:0]  r_bcd;
    logic [HAND_W-1:0] r_bin;
    logic              r_ovf;
    logic [HAND_W-1:0] w_hand_sel;
    logic [SR_W-1:0]   w_adj;
    logic [HGL_W-1:0]  w_glyphs;

    assign w_adj    = {bcd_adjust(r_bcd), r_bin};
    assign w_glyphs = hand_glyphs(r_bcd, r_ovf);

    // Select the hand currently addressed by the scan index.
    always_comb begin
        w_hand_sel = '0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            w_hand_sel = (r_idx == IDX_W'(h)) ? i_hand_vals[h*HAND_W +: HAND_W] : w_hand_sel;
        end
    end

    // Converter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conv_state <= ST_IDLE;
        end else begin
            r_conv_state <= w_conv_next;
        end
    end

    // Converter next-state logic; IDLE always proceeds so the scan never stops.
    always_comb begin
        w_conv_next = ST_IDLE;
        case (r_conv_state)
            ST_IDLE:   w_conv_next = ST_LOAD;
            ST_LOAD:   w_conv_next = ST_SHIFT;
            ST_SHIFT:  w_conv_next = (r_bit == BIT_W'(HAND_W - 1)) ? ST_COMMIT : ST_SHIFT;
            ST_COMMIT: w_conv_next = ST_IDLE;
            default:   w_conv_next = ST_IDLE;
        endcase
    end

    // Snapshot, shift-add-3 iterations and scan index advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_bit <= '0;
            r_bcd <= '0;
            r_bin <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_conv_state)
                ST_LOAD: begin
                    r_bin <= w_hand_sel;
                    r_bcd <= '0;
                    r_bit <= '0;
                    r_ovf <= (32'(w_hand_sel) >= OVF_LIMIT);
                end
                ST_SHIFT: begin
                    {r_bcd, r_bin} <= {w_adj[SR_W-2:0], 1'b0};
                    r_bit          <= r_bit + BIT_W'(1);
                end
                ST_COMMIT: begin
                    r_idx <= (r_idx == IDX_W'(NUM_HANDS - 1)) ? '0 : r_idx + IDX_W'(1);
                end
                default: begin
                    r_bit <= r_bit;
                end
            endcase
        end
    end

    // Hand digit registers change only on commit, so a partial conversion is never visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hex_hands <= '1;
            o_hand_upd  <= '0;
        end else begin
            o_hand_upd <= '0;
            if (r_conv_state == ST_COMMIT) begin
                for (int h = 0; h < NUM_HANDS; h++) begin
                    if (r_idx == IDX_W'(h)) begin
                        o_hex_hands[h*HGL_W +: HGL_W] <= w_glyphs;
                        o_hand_upd[h]                 <= 1'b1;
                    end
                end
            end
        end
    end

    logic [STATE_W-1:0] r_state;
    logic               r_state_vld;
    logic               r_player_bj;
    logic               w_result;
    logic               w_phase_on;
    logic [19:0]        w_msg_codes;
    logic [27:0]        w_msg_segs;

    // Game state and blackjack flag are registered together so the message decodes one snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RESET;
            r_state_vld <= 1'b0;
            r_player_bj <= 1'b0;
        end else begin
            r_state     <= i_game_state;
            r_state_vld <= 1'b1;
            r_player_bj <= (32'(i_hand_vals[HAND_W-1:0]) == 32'd21);
        end
    end

    assign w_result = (r_state == S_RESULT_WIN) || (r_state == S_RESULT_LOSE) ||
                      (r_state == S_RESULT_TIE);

`ifdef HAND_DISPLAY_BLINK_EN
    localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_phase_on;
    logic             w_state_chg;

    assign w_state_chg = (i_game_state != r_state);

    // Flash timer: restarts "on" whenever the registered state changes, runs only in result states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (w_state_chg || !w_result) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (r_blink_cnt == BLK_W'(BLINK_CYCLES - 1)) begin
            r_blink_cnt <= '0;
            r_phase_on  <= ~r_phase_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLK_W'(1);
        end
    end

    assign w_phase_on = r_phase_on;
`else
    assign w_phase_on = 1'b1;
`endif

    // Message text selection and glyph decode, blanked before the first state sample and when flashed off.
    always_comb begin
        w_msg_codes = {C_P, C_L, C_A, C_Y};
        case (r_state)
            S_RESET:       w_msg_codes = {C_S, C_T, C_R, C_T};
            S_RESULT_WIN:  w_msg_codes = r_player_bj ? {C_B, C_L, C_J, C_K} : {C_BLANK, C_W, C_I, C_N};
            S_RESULT_LOSE: w_msg_codes = {C_L, C_O, C_S, C_E};
            S_RESULT_TIE:  w_msg_codes = {C_BLANK, C_T, C_I, C_E};
            default:       w_msg_codes = {C_P, C_L, C_A, C_Y};
        endcase
        w_msg_segs = '1;
        if (r_state_vld && (w_phase_on || !w_result)) begin
            for (int c = 0; c < 4; c++) begin
                w_msg_segs[c*7 +: 7] = seg_decode(w_msg_codes[c*5 +: 5]);
            end
        end else begin
            w_msg_segs = '1;
        end
    end

    // Message output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hex_msg <= '1;
        end else begin
            o_hex_msg <= w_msg_segs;
        end
    end

endmodule

// File: tb/tb_hand_display_scan.sv
// Directed bench for hand_display_scan: reset, conversion scan, snapshot rule, blanking,
// overflow (7-bit instance), message decode and flash/steady behaviour.
module tb_hand_display_scan;

    localparam logic [2:0] ST_RESET = 3'd0;
    localparam logic [2:0] ST_PLAY  = 3'd1;
    localparam logic [2:0] ST_WIN   = 3'd5;
    localparam logic [2:0] ST_LOSE  = 3'd6;
    localparam logic [2:0] ST_TIE   = 3'd7;

    localparam logic [6:0] G0 = 7'h40;
    localparam logic [6:0] G1 = 7'h79;
    localparam logic [6:0] G2 = 7'h24;
    localparam logic [6:0] G7 = 7'h78;
    localparam logic [6:0] G9 = 7'h10;
    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] DS = 7'h3F;

    localparam logic [27:0] MSG_BLANK = 28'hFFFFFFF;
    localparam logic [27:0] MSG_STRT  = {7'h12, 7'h07, 7'h2F, 7'h07};
    localparam logic [27:0] MSG_PLAY  = {7'h0C, 7'h47, 7'h08, 7'h11};
    localparam logic [27:0] MSG_LOSE  = {7'h47, 7'h40, 7'h12, 7'h06};
    localparam logic [27:0] MSG_WIN   = {7'h7F, 7'h41, 7'h4F, 7'h2B};
    localparam logic [27:0] MSG_TIE   = {7'h7F, 7'h07, 7'h4F, 7'h06};
    localparam logic [27:0] MSG_BLJK  = {7'h03, 7'h47, 7'h61, 7'h09};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  hand_vals;
    logic [2:0]  game_state;
    logic [27:0] hex_hands;
    logic [27:0] hex_msg;
    logic [1:0]  hand_upd;
    logic [13:0] hv7;
    logic [27:0] hh7;
    logic [27:0] hm7;
    logic [1:0]  hu7;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hand_display_scan #(.HAND_W(5), .NUM_HANDS(2), .HAND_DIGITS(2), .BLINK_CYCLES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_hand_vals(hand_vals), .i_game_state(game_state),
        .o_hex_hands(hex_hands), .o_hex_msg(hex_msg), .o_hand_upd(hand_upd)
    );

    hand_display_scan #(.HAND_W(7), .NUM_HANDS(2), .HAND_DIGITS(2), .BLINK_CYCLES(4)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .i_hand_vals(hv7), .i_game_state(game_state),
        .o_hex_hands(hh7), .o_hex_msg(hm7), .o_hand_upd(hu7)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for the next hand_upd[h] pulse; count cycles where hand h's digits differ from hold.
    task automatic wait_upd(input int h, input int budget, input logic [13:0] hold,
                            input string tag, output int glitches);
        int n;
        n = 0;
        glitches = 0;
        do begin
            @(negedge clk);
            n++;
            if (hand_upd[h] !== 1'b1 && hex_hands[h*14 +: 14] !== hold) glitches++;
        end while (hand_upd[h] !== 1'b1 && n < budget);
        check(tag, {31'd0, hand_upd[h]}, 32'd1);
    endtask

    initial begin
        int g;
        int n;
        int cnt1;
        logic [27:0] exp_msg;

        hand_vals  = {5'd7, 5'd21};
        game_state = ST_WIN;
        hv7        = {7'd99, 7'd100};
        repeat (3) @(negedge clk);
        check("reset hands", hex_hands, 28'hFFFFFFF);
        check("reset msg", hex_msg, MSG_BLANK);
        check("reset upd", hand_upd, 2'b00);
        game_state = ST_RESET;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("msg 1 edge after release", hex_msg, MSG_BLANK);
        @(negedge clk);
        check("msg STRT 2 edges after release", hex_msg, MSG_STRT);
        check("hands blank before commit", hex_hands, 28'hFFFFFFF);

        wait_upd(0, 40, 14'h3FFF, "first player commit", g);
        check("player 21", hex_hands[13:0], {G2, G1});
        n = 0;
        cnt1 = 0;
        do begin
            @(negedge clk);
            n++;
            if (hand_upd[1] === 1'b1) cnt1++;
        end while (hand_upd[0] !== 1'b1 && n < 40);
        check("scan period", n, 16);
        check("dealer pulses per scan", cnt1, 1);
        check("dealer 7", hex_hands[27:14], {BL, G7});

        wait_upd(1, 20, {BL, G7}, "dealer commit before snapshot test", g);
        hand_vals[4:0] = 5'd9;
        repeat (3) @(negedge clk);
        check("no early change", hex_hands[13:0], {G2, G1});
        hand_vals[4:0] = 5'd17;
        wait_upd(0, 20, {G2, G1}, "snapshot commit", g);
        check("snapshot glitches", g, 0);
        check("snapshot shows 9", hex_hands[13:0], {BL, G9});
        wait_upd(0, 20, {BL, G9}, "next commit", g);
        check("next commit glitches", g, 0);
        check("player 17", hex_hands[13:0], {G1, G7});

        hand_vals[4:0] = 5'd0;
        wait_upd(0, 20, {G1, G7}, "zero commit a", g);
        wait_upd(0, 20, {BL, G0}, "zero commit b", g);
        check("player 0", hex_hands[13:0], {BL, G0});
        check("dealer unchanged", hex_hands[27:14], {BL, G7});

        game_state = ST_PLAY;
        @(negedge clk);
        check("msg latency 1", hex_msg, MSG_STRT);
        @(negedge clk);
        check("msg PLAY", hex_msg, MSG_PLAY);
        game_state = ST_WIN;
        repeat (2) @(negedge clk);
        check("msg WIN", hex_msg, MSG_WIN);
        game_state = ST_LOSE;
        repeat (2) @(negedge clk);
        check("msg LOSE", hex_msg, MSG_LOSE);

        hand_vals[4:0] = 5'd21;
        game_state = ST_WIN;
        @(negedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
`ifdef HAND_DISPLAY_BLINK_EN
            if (k <= 4)       exp_msg = MSG_BLJK;
            else if (k <= 8)  exp_msg = MSG_BLANK;
            else if (k <= 12) exp_msg = MSG_BLJK;
            else if (k <= 15) exp_msg = MSG_BLANK;
            else if (k <= 19) exp_msg = MSG_TIE;
            else              exp_msg = MSG_BLANK;
`else
            exp_msg = (k <= 15) ? MSG_BLJK : MSG_TIE;
`endif
            check($sformatf("flash k=%0d", k), hex_msg, exp_msg);
            if (k == 14) game_state = ST_TIE;
        end

        check("w7 player 100 dashes", hh7[13:0], {DS, DS});
        check("w7 dealer 99", hh7[27:14], {G9, G9});

        wait_upd(1, 20, {BL, G7}, "dealer commit before async reset", g);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset hands", hex_hands, 28'hFFFFFFF);
        check("async reset msg", hex_msg, MSG_BLANK);
        check("async reset upd", hand_upd, 2'b00);
        cnt1 = 0;
        repeat (2) begin
            @(negedge clk);
            if (hand_upd !== 2'b00) cnt1++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (hand_upd !== 2'b00) cnt1++;
        end
        check("no pulse from abandoned conversion", cnt1, 0);
        check("hands blank after re-reset", hex_hands, 28'hFFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
